// File: rtl/cpu_sequencer.sv
// Fetch/execute sequencer for the 8-bit accumulator CPU: eight-phase controller
// with wait states and timeout, illegal-opcode trap, resumable halt and single-step.
module cpu_sequencer #(
  parameter int OPW    = 3,
  parameter int WAIT_W = 4
) (
  input  logic           clk,
  input  logic           rst_,
  input  logic [OPW-1:0] opcode,
  input  logic           zero,
  input  logic           mem_rdy,
  input  logic           run,
  input  logic           step_mode,
  output logic           rd,
  output logic           wr,
  output logic           ld_ir,
  output logic           ld_ac,
  output logic           ld_pc,
  output logic           inc_pc,
  output logic           data_e,
  output logic           sel,
  output logic           halt,
  output logic           paused,
  output logic           illegal,
  output logic           bus_err,
  output logic [2:0]     phase
);

  typedef enum logic [1:0] {
    M_RUN    = 2'd0,
    M_HALTED = 2'd1,
    M_PAUSED = 2'd2,
    M_FAULT  = 2'd3
  } mode_t;

  // Last count before the stall counter saturates at all-ones.
  localparam logic [WAIT_W-1:0] STALL_LAST = WAIT_W'((2 ** WAIT_W) - 2);

  mode_t             r_mode;
  logic [2:0]        r_phase;
  logic [WAIT_W-1:0] r_stall;
  logic              r_illegal;
  logic              r_bus_err;

  logic [2:0] w_op;
  logic       w_bad_op;
  logic       w_run;
  logic       w_hlt, w_skz, w_sto, w_jmp, w_aluop;
  logic       w_adv;

  assign w_op = opcode[2:0];

  generate
    if (OPW > 3) begin : g_wide_op
      assign w_bad_op = |opcode[OPW-1:3];
    end else begin : g_base_op
      assign w_bad_op = 1'b0;
    end
  endgenerate

  assign w_run   = (r_mode == M_RUN);
  assign w_hlt   = !w_bad_op && (w_op == 3'd0);
  assign w_skz   = !w_bad_op && (w_op == 3'd1);
  assign w_sto   = !w_bad_op && (w_op == 3'd6);
  assign w_jmp   = !w_bad_op && (w_op == 3'd7);
  assign w_aluop = !w_bad_op && (w_op >= 3'd2) && (w_op <= 3'd5);

  // Strobes depend only on registered phase/mode and the stable IR/zero inputs,
  // never on mem_rdy.
  always_comb begin
    rd     = 1'b0;
    wr     = 1'b0;
    ld_ir  = 1'b0;
    ld_ac  = 1'b0;
    ld_pc  = 1'b0;
    inc_pc = 1'b0;
    data_e = 1'b0;
    sel    = !r_phase[2];
    if (w_run) begin
      case (r_phase)
        3'd1: rd = 1'b1;
        3'd2, 3'd3: begin
          rd    = 1'b1;
          ld_ir = 1'b1;
        end
        3'd4: inc_pc = !w_bad_op;
        3'd5: rd = w_aluop;
        3'd6: begin
          rd     = w_aluop;
          inc_pc = w_skz && zero;
          ld_pc  = w_jmp;
          data_e = w_sto;
        end
        3'd7: begin
          rd     = w_aluop;
          ld_ac  = w_aluop;
          ld_pc  = w_jmp;
          wr     = w_sto;
          data_e = w_sto;
        end
        default: ;
      endcase
    end
  end

  assign w_adv = !(rd || wr) || mem_rdy;

  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      r_mode    <= M_RUN;
      r_phase   <= 3'd0;
      r_stall   <= '0;
      r_illegal <= 1'b0;
      r_bus_err <= 1'b0;
    end else begin
      case (r_mode)
        M_RUN: begin
          if (!w_adv) begin
            r_stall <= r_stall + WAIT_W'(1);
            if (r_stall == STALL_LAST) begin
              r_bus_err <= 1'b1;
              r_mode    <= M_FAULT;
            end
          end else begin
            r_stall <= '0;
            if (r_phase == 3'd4 && w_bad_op) begin
              // Trap before the operand phases; phase stays at 4.
              r_illegal <= 1'b1;
              r_mode    <= M_FAULT;
            end else begin
              r_phase <= r_phase + 3'd1;
              if (r_phase == 3'd4 && w_hlt)
                r_mode <= M_HALTED;
              if (r_phase == 3'd7 && step_mode)
                r_mode <= M_PAUSED;
            end
          end
        end
        M_HALTED, M_PAUSED: begin
          if (run)
            r_mode <= M_RUN;
        end
        default: ;
      endcase
    end
  end

  assign halt    = (r_mode == M_HALTED) || (r_mode == M_FAULT);
  assign paused  = (r_mode == M_PAUSED);
  assign illegal = r_illegal;
  assign bus_err = r_bus_err;
  assign phase   = r_phase;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: directed scenarios with literal expectations, then
// random stimulus compared every cycle against a behavioural model.
module tb_cpu_sequencer;
  localparam int OPW    = 4;
  localparam int WAIT_W = 4;
  localparam int M_RUN = 0, M_HALT = 1, M_PAUSE = 2, M_FAULT = 3;

  logic           clk = 1'b0;
  logic           rst_;
  logic [OPW-1:0] opcode;
  logic           zero, mem_rdy, run, step_mode;
  logic           rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, sel;
  logic           halt, paused, illegal, bus_err;
  logic [2:0]     phase;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cpu_sequencer #(.OPW(OPW), .WAIT_W(WAIT_W)) dut (
    .clk(clk), .rst_(rst_), .opcode(opcode), .zero(zero), .mem_rdy(mem_rdy),
    .run(run), .step_mode(step_mode), .rd(rd), .wr(wr), .ld_ir(ld_ir),
    .ld_ac(ld_ac), .ld_pc(ld_pc), .inc_pc(inc_pc), .data_e(data_e), .sel(sel),
    .halt(halt), .paused(paused), .illegal(illegal), .bus_err(bus_err),
    .phase(phase)
  );

  // Expected {rd,wr,ld_ir,ld_ac,ld_pc,inc_pc,data_e,sel} from the phase table.
  function automatic logic [7:0] exp_strobes(input int ph, input int op,
                                              input bit z, input int md);
    bit          alu;
    logic [7:0]  s;
    alu  = (op >= 2 && op <= 5);
    s    = '0;
    s[0] = (ph < 4);
    if (md == M_RUN) begin
      s[7] = (ph >= 1 && ph <= 3) || (ph >= 5 && alu);
      s[6] = (ph == 7 && op == 6);
      s[5] = (ph == 2 || ph == 3);
      s[4] = (ph == 7 && alu);
      s[3] = (ph >= 6 && op == 7);
      s[2] = (ph == 4 && op < 8) || (ph == 6 && op == 1 && z);
      s[1] = (ph >= 6 && op == 6);
    end
    return s;
  endfunction

  // Behavioural model state.
  int m_phase  = 0;
  int m_mode   = M_RUN;
  int m_stalls = 0;
  bit m_ill    = 1'b0;
  bit m_berr   = 1'b0;

  always @(posedge clk or posedge rst_) begin
    logic [7:0] s;
    if (rst_) begin
      m_phase = 0; m_mode = M_RUN; m_stalls = 0; m_ill = 0; m_berr = 0;
    end else if (m_mode == M_RUN) begin
      s = exp_strobes(m_phase, int'(opcode), zero, m_mode);
      if ((s[7] || s[6]) && !mem_rdy) begin
        m_stalls = m_stalls + 1;
        if (m_stalls == (1 << WAIT_W) - 1) begin
          m_berr = 1; m_mode = M_FAULT;
        end
      end else begin
        m_stalls = 0;
        if (m_phase == 4 && opcode >= 8) begin
          m_ill = 1; m_mode = M_FAULT;
        end else if (m_phase == 4 && opcode == 0) begin
          m_phase = 5; m_mode = M_HALT;
        end else if (m_phase == 7) begin
          m_phase = 0;
          if (step_mode) m_mode = M_PAUSE;
        end else begin
          m_phase = m_phase + 1;
        end
      end
    end else if ((m_mode == M_HALT || m_mode == M_PAUSE) && run) begin
      m_mode = M_RUN;
    end
  end

  always @(negedge clk) begin
    logic [14:0] got, exp;
    exp = {exp_strobes(m_phase, int'(opcode), zero, m_mode),
           (m_mode == M_HALT || m_mode == M_FAULT), (m_mode == M_PAUSE),
           m_ill, m_berr, 3'(m_phase)};
    got = {rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, sel,
           halt, paused, illegal, bus_err, phase};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL cycle_outputs t=%0t got %b expected %b", $time, got, exp);
    end
  end

  task automatic lit(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic to_phase(input int p);
    int k;
    k = 0;
    while (int'(phase) != p && k < 40) begin
      cyc(1);
      k++;
    end
    lit("reach_phase", int'(phase), p);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [7:0] mask;
    int n, st, burst;
    rst_ = 1'b1; opcode = 4'd2; zero = 1'b0; mem_rdy = 1'b1; run = 1'b0; step_mode = 1'b0;
    burst = 0;

    lit("model_p7_add", int'(exp_strobes(7, 2, 0, M_RUN)), 8'b1001_0000);
    lit("model_p6_skz", int'(exp_strobes(6, 1, 1, M_RUN)), 8'b0000_0100);
    lit("model_p2_fault", int'(exp_strobes(2, 2, 0, M_FAULT)), 8'b0000_0001);

    cyc(2);
    lit("rst_phase", int'(phase), 0);
    lit("rst_sel", int'(sel), 1);
    lit("rst_others", int'({rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e,
                            halt, paused, illegal, bus_err}), 0);
    rst_ = 1'b0;

    // ADD: one phase per clock.
    for (int k = 0; k < 8; k++) begin
      lit("add_phase", int'(phase), k);
      if (k == 2) lit("add_ld_ir", int'(ld_ir), 1);
      if (k == 7) lit("add_p7_rd_ldac", int'({rd, ld_ac}), 3);
      cyc(1);
    end
    lit("add_wrap", int'(phase), 0);

    // SKZ with and without zero.
    opcode = 4'd1; zero = 1'b1; mask = '0;
    for (int k = 0; k < 8; k++) begin mask[k] = inc_pc; cyc(1); end
    lit("skz_zero1_inc_pc", int'(mask), 8'h50);
    zero = 1'b0; mask = '0;
    for (int k = 0; k < 8; k++) begin mask[k] = inc_pc; cyc(1); end
    lit("skz_zero0_inc_pc", int'(mask), 8'h10);

    // HLT and resume.
    opcode = 4'd0;
    to_phase(4);
    lit("hlt_inc_pc", int'(inc_pc), 1);
    cyc(1);
    lit("hlt_halt", int'(halt), 1);
    lit("hlt_phase", int'(phase), 5);
    cyc(20);
    lit("hlt_hold", int'({halt, phase}), 13);
    run = 1'b1; cyc(1); run = 1'b0;
    lit("hlt_resumed", int'(halt), 0);
    lit("hlt_resume_phase", int'(phase), 5);
    cyc(1);
    lit("hlt_advance", int'(phase), 6);
    to_phase(0);

    // Illegal opcode trap.
    opcode = 4'd9;
    to_phase(4);
    lit("ill_no_inc_pc", int'(inc_pc), 0);
    cyc(1);
    lit("ill_flags", int'({illegal, halt, phase}), 28);
    run = 1'b1; cyc(1); run = 1'b0; cyc(3);
    lit("ill_run_ignored", int'({illegal, halt, phase}), 28);
    rst_ = 1'b1; cyc(1);
    lit("ill_reset", int'({illegal, phase}), 0);
    rst_ = 1'b0; opcode = 4'd5;

    // LDA with three wait states in phase 5.
    n = 0; st = 0;
    do begin
      if (int'(phase) == 5 && st < 3) begin mem_rdy = 1'b0; st++; end
      else mem_rdy = 1'b1;
      cyc(1);
      n++;
    end while (int'(phase) != 0 && n < 40);
    lit("lda_cycles", n, 11);
    mem_rdy = 1'b1;

    // Wait-state timeout in phase 1.
    opcode = 4'd2;
    cyc(1);
    mem_rdy = 1'b0;
    cyc(14);
    lit("tmo_not_yet", int'({bus_err, phase}), 1);
    cyc(1);
    lit("tmo_bus_err", int'({bus_err, halt}), 3);
    mem_rdy = 1'b1;
    rst_ = 1'b1; cyc(1); rst_ = 1'b0;

    // Single-step with JMP.
    step_mode = 1'b1; opcode = 4'd7;
    for (int k = 0; k < 8; k++) begin
      if (k >= 6) lit("jmp_ld_pc", int'(ld_pc), 1);
      cyc(1);
    end
    lit("step_paused", int'({paused, phase}), 8);
    cyc(3);
    lit("step_hold", int'({paused, phase}), 8);
    run = 1'b1; cyc(1); run = 1'b0;
    lit("step_resumed", int'(paused), 0);
    step_mode = 1'b0;
    cyc(1);
    lit("step_next_fetch", int'(phase), 1);
    to_phase(0);

    // Random stimulus against the model.
    for (int i = 0; i < 4000; i++) begin
      if (m_phase == 0 && m_mode == M_RUN)
        opcode = ($urandom % 10 == 0) ? OPW'(8 + $urandom % 8) : OPW'($urandom % 8);
      zero = 1'($urandom % 2);
      if (i % 500 == 250) burst = 18;
      if (burst > 0) begin mem_rdy = 1'b0; burst--; end
      else mem_rdy = ($urandom % 4) != 0;
      run = ($urandom % 6 == 0);
      if ($urandom % 40 == 0) step_mode = ~step_mode;
      rst_ = (m_mode == M_FAULT && $urandom % 6 == 0) || ($urandom % 300 == 0);
      cyc(1);
    end

    rst_ = 1'b0; run = 1'b0;
    cyc(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Parametrised fetch/execute sequencer for the 8-bit accumulator CPU. It is the next generation of the core's eight-phase controller. It drives the same nine datapath/memory strobes from the instruction opcode and the accumulator zero flag. It adds a wider opcode field with illegal-opcode trapping, memory wait-state handshaking with timeout, resumable halt, and single-step operation. It sits between the instruction register/ALU zero flag and the PC, accumulator, IR load enables and the memory bus.

## Interface
- OPW, 3: opcode field width (≥3); codes 0–7 are the base ISA (HLT SKZ ADD AND XOR LDA STO JMP); codes ≥8 are illegal.
- WAIT_W, 4: width of the stall counter; timeout fires after 2^WAIT_W−1 consecutive stalled cycles.
- clk  in  1  rising-edge clock.
- rst_  in  1  reset, asynchronous, active-high.
- opcode  in  OPW  current instruction opcode from IR.
- zero  in  1  accumulator-zero flag.
- mem_rdy  in  1  memory ready; qualifies phases asserting rd or wr.
- run  in  1  one-cycle resume pulse (from HLT halt or step pause).
- step_mode  in  1  pause after each completed instruction.
- rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, sel  out  1 each  datapath/memory strobes.
- halt  out  1  high while halted by HLT, illegal opcode or bus error.
- paused  out  1  high while waiting at a step boundary.
- illegal  out  1  sticky; illegal opcode decoded.
- bus_err  out  1  sticky; wait-state timeout.
- phase  out  3  current phase (0–7).

## Operation
- Phases: 0 INST_ADDR, 1 INST_FETCH, 2 INST_LOAD, 3 IDLE, 4 OP_ADDR, 5 OP_FETCH, 6 ALU_OP, 7 STORE. Phase 7 wraps to 0.
- Mode register: RUN, HALTED, PAUSED, FAULT. Strobes are decoded combinationally from phase, opcode and zero. All strobes are 0 outside RUN, except sel in phases 0–3.
- ALUOP = ADD|AND|XOR|LDA.
- Phase 0: sel.
- Phase 1: sel, rd.
- Phase 2: sel, rd, ld_ir.
- Phase 3: sel, rd, ld_ir.
- Phase 4: inc_pc.
- Phase 5: rd=ALUOP.
- Phase 6: rd=ALUOP, inc_pc=SKZ&zero, ld_pc=JMP, data_e=STO.
- Phase 7: rd=ALUOP, ld_ac=ALUOP, ld_pc=JMP, wr=STO, data_e=STO.
- Wait states: a phase that asserts rd or wr advances only when mem_rdy=1. Other phases advance every cycle.
- Stall counter: clears on every advance and increments each stalled cycle. Reaching 2^WAIT_W−1 sets bus_err and enters FAULT.
- HLT at phase 4: completes phase 4 (inc_pc pulses once), then enters HALTED with phase held at 5. A run pulse resumes RUN at phase 5.
- Illegal opcode (≥8) at phase 4: sets illegal and enters FAULT at phase 4 with no inc_pc. With OPW=3, illegal is constant 0.
- FAULT is exited only by reset; run is ignored in FAULT.
- step_mode=1 at phase 7 advance: goes to PAUSED at phase 0. A run pulse resumes RUN.
- run while RUN is ignored.
- run and a step boundary in the same cycle: the pause still occurs; run must be reapplied.
- Reset (any mode, mid-stall included): phase 0, mode RUN, stall counter 0, illegal=0, bus_err=0.
- Reset values: sel=1; all other outputs 0; phase=0.

## Timing
- Zero-wait instruction: 8 cycles, one phase per clock. Each stalled cycle adds 1.
- Strobes change only after rising edges or on reset assertion, with no glitch-sensitive paths from mem_rdy.
- run is sampled on the rising edge. RUN resumes the cycle after run is sampled high.
- halt/paused/illegal/bus_err assert the cycle after the causing edge.
- Timeout: with WAIT_W=4 and mem_rdy held low in phase 1, bus_err rises after the 15th stalled cycle.

## Test plan
- Reset then ADD (2, zero=0), mem_rdy=1 -> phases 0..7 in 8 cycles. Phase 7 gives rd=1, ld_ac=1; phase 2 gives ld_ir=1.
- SKZ with zero=1 -> inc_pc=1 in phases 4 and 6. With zero=0 -> inc_pc only in phase 4.
- HLT -> inc_pc pulse in phase 4, then halt=1 with phase=5. After 20 idle cycles, run pulse -> halt=0, phase advances 5→6.
- OPW=4, opcode=9 at phase 4 -> illegal=1, halt=1, inc_pc=0. run has no effect; rst_ pulse -> phase 0, illegal=0.
- LDA with mem_rdy=0 for 3 cycles in phase 5 -> phase holds 3 extra cycles, total 11 cycles. mem_rdy low for 15 cycles in phase 1 (WAIT_W=4) -> bus_err=1.
- step_mode=1, JMP -> ld_pc in phases 6–7, then paused=1 at phase 0. run -> next instruction fetch.
